// File: rtl/parity_frame_tx_pkg.sv
// Shared constants for the parity frame transmitter: state encoding, parity modes and line levels.
package parity_frame_tx_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StStart  = 3'd1;
  localparam logic [2:0] StData   = 3'd2;
  localparam logic [2:0] StParity = 3'd3;
  localparam logic [2:0] StStop   = 3'd4;

  localparam logic ParOdd  = 1'b1;
  localparam logic ParEven = 1'b0;

  localparam logic LineIdle = 1'b1;
  localparam logic StartBit = 1'b0;
  localparam logic StopBit  = 1'b1;

endpackage

// File: rtl/parity_frame_tx_if.sv
// Producer-side handshake plus serial-line status bundle for parity_frame_tx.
interface parity_frame_tx_if #(
  parameter int unsigned DATA_W = 8
);
  localparam int unsigned IdxW = $clog2(DATA_W);

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              abort;
  logic              ser_out;
  logic              busy;
  logic [IdxW-1:0]   bit_idx;
  logic              frame_done;

  modport master (
    output in_data, in_valid, abort,
    input  in_ready, ser_out, busy, bit_idx, frame_done
  );

  modport slave (
    input  in_data, in_valid, abort,
    output in_ready, ser_out, busy, bit_idx, frame_done
  );
endinterface

// File: rtl/serial_parity_acc.sv
// Single-flop running parity: load seeds the value, en folds one serial bit in per clock.
module serial_parity_acc (
  input  logic clk,
  input  logic arst,
  input  logic load,
  input  logic init,
  input  logic en,
  input  logic din,
  output logic par
);

  logic par_q;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= init;
    end else if (en) begin
      par_q <= par_q ^ din;
    end
  end

  assign par = par_q;

endmodule

// File: rtl/parity_frame_tx.sv
// Frame sequencer: start bit, DATA_W data bits LSB first, parity bit, stop bit on one serial line.
module parity_frame_tx
  import parity_frame_tx_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter bit          ODD    = 1'b1
) (
  input logic               clk,
  input logic               arst,
  parity_frame_tx_if.slave  bus
);

  localparam int unsigned     CntW    = $clog2(DATA_W);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  logic [2:0]        state_q, state_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              accept;
  logic              acc_load;
  logic              acc_init;
  logic              acc_en;
  logic              par;

  assign bus.in_ready = ((state_q == StIdle) || (state_q == StStop)) && !bus.abort;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    if (bus.abort) begin
      state_d = StIdle;
      shift_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle, StStop: begin
          // STOP accepting straight into START gives back-to-back frames with no idle gap.
          if (accept) begin
            state_d = StStart;
            shift_d = bus.in_data;
          end else begin
            state_d = StIdle;
          end
        end
        StStart: begin
          state_d = StData;
          cnt_d   = '0;
        end
        StData: begin
          shift_d = shift_q >> 1;
          if (cnt_q == CntLast) begin
            state_d = StParity;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StParity: state_d = StStop;
        default:  state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q <= StIdle;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort reuses the load path to clear the accumulator.
  assign acc_load = accept || bus.abort;
  assign acc_init = bus.abort ? 1'b0 : (ODD ? ParOdd : ParEven);
  assign acc_en   = (state_q == StData);

  serial_parity_acc u_acc (
    .clk  (clk),
    .arst (arst),
    .load (acc_load),
    .init (acc_init),
    .en   (acc_en),
    .din  (shift_q[0]),
    .par  (par)
  );

  always_comb begin
    bus.ser_out = LineIdle;
    case (state_q)
      StStart:  bus.ser_out = StartBit;
      StData:   bus.ser_out = shift_q[0];
      StParity: bus.ser_out = par;
      StStop:   bus.ser_out = StopBit;
      default:  bus.ser_out = LineIdle;
    endcase
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.frame_done = (state_q == StStop);
  assign bus.bit_idx    = (state_q == StData) ? cnt_q : '0;

endmodule
